add_round_key_stage: RTL
========================

ADD_ROUND_KEY_STAGE -- requirements
Module: add_round_key_stage

Interface
REQ-001 SHALL have parameter NUM_KEYS, default 11, number of round-key table entries (rounds 0..10).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port n_rst  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  upstream (MixColumns stage) presents a word.
REQ-005 SHALL have port in_ready  output  1  stage accepts a word this cycle.
REQ-006 SHALL have port data_in  input  132  [131:128] header (round number), [127:0] state; column c at [c*32 +: 32], row r byte at [c*32 + r*8 +: 8].
REQ-007 SHALL have port key_we  input  1  round-key table write strobe.
REQ-008 SHALL have port key_addr  input  4  round-key table index.
REQ-009 SHALL have port key_data  input  128  round key, same byte layout as the state.
REQ-010 SHALL have port out_valid  output  1  output word available.
REQ-011 SHALL have port out_ready  input  1  downstream accepts the output word.
REQ-012 SHALL have port data_out  output  132  [131:128] header passed through, [127:0] state XOR round key.
REQ-013 SHALL have port header_out  output  4  copy of data_out[131:128].
REQ-014 SHALL have port err  output  1  head-of-buffer word carried an out-of-range header (ARK_HDR_CHECK_EN only).

Function
REQ-015 SHALL accept a word when in_valid and in_ready are both high (push).
REQ-016 SHALL compute result = {hdr, state XOR key_table[hdr]} using the table contents before any same-cycle key write.
REQ-017 SHALL store results in a 2-entry in-order output FIFO; accepted word is visible at the output on the next cycle (1-cycle latency).
REQ-018 SHALL drive in_ready = (count < 2), purely from registered count; no combinational path from out_ready to in_ready.
REQ-019 SHALL pop the head entry when out_valid and out_ready are both high; out_valid = (count != 0).
REQ-020 SHALL, on simultaneous push and pop, leave count unchanged and preserve ordering.
REQ-021 SHALL hold data_out, header_out and err stable while out_valid is high and out_ready is low.
REQ-022 SHALL write key_table[key_addr] = key_data when key_we is high and key_addr < NUM_KEYS; writes with key_addr >= NUM_KEYS are ignored.
REQ-023 SHALL use a header >= NUM_KEYS as a key of all zeros (state passes through unchanged).
REQ-024 SHALL ignore data_in when in_valid is low or in_ready is low; a dropped push is not buffered.
REQ-025 SHALL wrap FIFO read/write pointers modulo 2.

Reset
REQ-026 SHALL, when n_rst is low at a rising edge, clear count and pointers, and drive out_valid=0, data_out=0, header_out=0, err=0, in_ready=1 the following cycle.
REQ-027 SHALL clear all round-key table entries to zero on reset.
REQ-028 SHALL, on reset mid-operation, discard buffered words; no push, pop or key write takes effect in the reset cycle.

Configuration
REQ-029 SHALL, when macro ARK_HDR_CHECK_EN is defined, store a per-entry error bit set when the header >= NUM_KEYS, and drive err from the head entry while out_valid is high.
REQ-030 SHALL, without ARK_HDR_CHECK_EN, tie err to 0 and store no error bits; all other behaviour is identical.

Verification
REQ-031 SHALL verify: reset, key 7 = 0x000102030405060708090a0b0c0d0e0f, push data_in 0x7d4bf5d30000000000000000000000000, out_ready=1 -> next cycle out_valid=1, header_out=7, data_out[127:0]=0xd4bf5d30000000000000000000000000 XOR key 7.
REQ-032 SHALL verify: out_ready=0, push 3 words with headers 1,2,3 on consecutive cycles -> in_ready low after 2nd push, 3rd word not accepted, outputs later pop as headers 1 then 2.
REQ-033 SHALL verify: count=1, push and pop same cycle for 10 cycles -> count stays 1, out_valid continuously high, order preserved.
REQ-034 SHALL verify: key_we to address 4 with 0xff..ff in the same cycle as a push with header 4 and zero state -> result uses old key (0); next push with header 4 returns all 0xff.
REQ-035 SHALL verify: push header 0xC (>= 11) with state 0x1234 -> data_out[127:0]=0x1234, err=1 with ARK_HDR_CHECK_EN, err=0 without.
REQ-036 SHALL verify: n_rst low with 2 buffered words -> next cycle out_valid=0, data_out=0, in_ready=1, and a header-7 push returns state unchanged (key cleared).

Source files
------------

// File: rtl/add_round_key_stage.sv
// -----------------------------------------------------------------------------
// add_round_key_stage
//   AES AddRoundKey pipeline stage with a 2-entry in-order output FIFO.
//   Each accepted word is {hdr, state}. The stage XORs the state with
//   key_table[hdr] and buffers the result. The result appears at the output
//   one cycle after it is accepted.
//
// Parameters
//   NUM_KEYS  : number of round-key table entries (default 11, rounds 0..10).
//
// Optional feature
//   ARK_HDR_CHECK_EN : if defined, each FIFO entry stores an error bit that
//                      flags header >= NUM_KEYS. err shows the bit of the
//                      head entry. If undefined, err is tied to 0.
//
// Ports
//   clk, n_rst           : clock and synchronous active-low reset
//   in_valid / in_ready  : upstream handshake. in_ready = (count < 2).
//   data_in[131:0]       : [131:128] round number, [127:0] state
//                          (column c at [c*32 +: 32]).
//   key_we/key_addr/key_data : round-key table write port
//   out_valid / out_ready: downstream handshake
//   data_out[131:0]      : {hdr, state ^ key}
//   header_out[3:0]      : copy of data_out[131:128]
//   err                  : head entry had an out-of-range header
// -----------------------------------------------------------------------------

// One 32-bit column of the AddRoundKey XOR.
module ark_lane #(
  parameter int VEC_W = 32
) (
  input  logic [VEC_W-1:0] col_i,
  input  logic [VEC_W-1:0] key_i,
  output logic [VEC_W-1:0] col_o
);
  assign col_o = col_i ^ key_i;
endmodule

module add_round_key_stage #(
  parameter int NUM_KEYS = 11
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [131:0] data_in,
  input  logic         key_we,
  input  logic [3:0]   key_addr,
  input  logic [127:0] key_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [131:0] data_out,
  output logic [3:0]   header_out,
  output logic         err
);

  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 32;

  // round-key table
  logic [127:0] key_tbl_q [NUM_KEYS];

  // fifo state
  logic [131:0] mem_q [2];
  logic         wptr_q, wptr_d;
  logic         rptr_q, rptr_d;
  logic [1:0]   cnt_q, cnt_d;

  logic push, pop;
  logic [3:0]   hdr;
  logic [127:0] key_sel;

  logic [NUM_LANES-1:0][VEC_W-1:0] st_cols, key_cols, res_cols;

  assign hdr = data_in[131:128];

  // Key lookup is a match loop, not a direct index. Headers >= NUM_KEYS
  // therefore fall through to the all-zero default, and the state passes
  // through unchanged. The read uses the registered table, so a key write in
  // the same cycle is not seen by this word.
  always_comb begin
    key_sel = '0;
    for (int k = 0; k < NUM_KEYS; k++)
      if (hdr == 4'(k)) key_sel = key_tbl_q[k];
  end

  assign st_cols  = data_in[127:0];
  assign key_cols = key_sel;

  ark_lane #(.VEC_W(VEC_W)) u_lane [NUM_LANES-1:0] (
    .col_i (st_cols),
    .key_i (key_cols),
    .col_o (res_cols)
  );

  // handshake; in_ready depends only on registered count
  assign in_ready  = (cnt_q < 2'd2);
  assign out_valid = (cnt_q != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    wptr_d = push ? ~wptr_q : wptr_q;
    rptr_d = pop  ? ~rptr_q : rptr_q;
    cnt_d  = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      cnt_q  <= '0;
      wptr_q <= 1'b0;
      rptr_q <= 1'b0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      for (int k = 0; k < NUM_KEYS; k++) key_tbl_q[k] <= '0;
    end else begin
      cnt_q  <= cnt_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      if (push) mem_q[wptr_q] <= {hdr, res_cols};
      // An address >= NUM_KEYS matches no entry, so the write is dropped.
      for (int k = 0; k < NUM_KEYS; k++)
        if (key_we && key_addr == 4'(k)) key_tbl_q[k] <= key_data;
    end
  end

  // The output is zero while the FIFO is empty. The head entry stays fixed
  // until it is popped, so the output is stable during a stall.
  assign data_out   = out_valid ? mem_q[rptr_q] : '0;
  assign header_out = data_out[131:128];

`ifdef ARK_HDR_CHECK_EN
  logic [1:0] err_q;
  logic       hdr_bad;

  assign hdr_bad = !(32'(hdr) < NUM_KEYS);

  always_ff @(posedge clk) begin
    if (!n_rst)    err_q <= '0;
    else if (push) err_q[wptr_q] <= hdr_bad;
  end

  assign err = out_valid & err_q[rptr_q];
`else
  assign err = 1'b0;
`endif

endmodule
